// File: rtl/example_pkg.sv
// Shared types and constants for the six-input sum-of-products evaluator.
package example_pkg;

   // Number of product terms evaluated per sample
   localparam int unsigned TERM_W = 3;

   typedef logic [TERM_W-1:0] term_t;

   // Bit positions of each product term within term_t
   localparam int unsigned TERM_AB = 0;
   localparam int unsigned TERM_CD = 1;
   localparam int unsigned TERM_EF = 2;

   // Value of the term vector while in reset
   localparam term_t TERMS_RESET = '0;

   // Builds the product-term vector from the six operands
   function automatic term_t sop_terms(input logic i_a, input logic i_b,
                                       input logic i_c, input logic i_d,
                                       input logic i_e, input logic i_f);
      term_t t;
      t          = TERMS_RESET;
      t[TERM_AB] = i_a & i_b;
      t[TERM_CD] = i_c & i_d;
      t[TERM_EF] = i_e & i_f;
      return t;
   endfunction

endpackage

// File: rtl/example_if.sv
// Sample/result bundle between a producer and the sum-of-products evaluator.
interface example_if;

   logic                  in_valid;
   logic                  a;
   logic                  b;
   logic                  c;
   logic                  d;
   logic                  e;
   logic                  f;
   logic                  y;
   example_pkg::term_t    terms;
   logic                  out_valid;

   // Producer side: drives samples, observes results
   modport master (
      output in_valid, a, b, c, d, e, f,
      input  y, terms, out_valid
   );

   // Evaluator side: consumes samples, drives results
   modport slave (
      input  in_valid, a, b, c, d, e, f,
      output y, terms, out_valid
   );

endinterface

// File: rtl/example_sop_comb.sv
// Combinational core: (A&B)|(C&D)|(E&F) plus the individual product terms.
module example_sop_comb
   import example_pkg::*;
(
   input  logic  i_a,
   input  logic  i_b,
   input  logic  i_c,
   input  logic  i_d,
   input  logic  i_e,
   input  logic  i_f,
   output term_t o_terms,
   output logic  o_y_next
);

   term_t w_terms;

   // Evaluate product terms and their OR
   always_comb begin
      w_terms  = sop_terms(i_a, i_b, i_c, i_d, i_e, i_f);
      o_terms  = w_terms;
      o_y_next = |w_terms;
   end

endmodule

// File: rtl/example_unit.sv
// Registered sum-of-products evaluator: one-cycle latency, no backpressure.
module example_unit
   import example_pkg::*;
#(
   parameter logic RESET_Y = 1'b0
) (
   input  logic     clk,
   input  logic     rst_n,
   example_if.slave bus
);

   term_t w_terms;
   logic  w_y_next;

   term_t r_terms;
   logic  r_y;
   logic  r_out_valid;

   example_sop_comb u_sop_comb (
      .i_a      (bus.a),
      .i_b      (bus.b),
      .i_c      (bus.c),
      .i_d      (bus.d),
      .i_e      (bus.e),
      .i_f      (bus.f),
      .o_terms  (w_terms),
      .o_y_next (w_y_next)
   );

   // Result registers: load only on an accepted sample so idle-cycle inputs
   // (including X/Z) never reach the outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= RESET_Y;
         r_terms <= TERMS_RESET;
      end else if (bus.in_valid) begin
         r_y     <= w_y_next;
         r_terms <= w_terms;
      end
   end

   // Output strobe: one pulse per accepted sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
      end
   end

   // Drive the result side of the bundle
   always_comb begin
      bus.y         = r_y;
      bus.terms     = r_terms;
      bus.out_valid = r_out_valid;
   end

endmodule

// File: tb/tb_example_unit.sv
// Self-checking bench for example_unit using an expected-result scoreboard.
module tb_example_unit;

   typedef struct packed {
      logic       y;
      logic [2:0] terms;
   } exp_t;

   logic clk;
   logic rst_n;

   exp_t sb_q[$];
   exp_t last_exp;
   int   n_checks;
   int   n_pass;

   example_if u_if ();

   example_unit #(
      .RESET_Y (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: s = {a,b,c,d,e,f}, terms = {e&f, c&d, a&b}
   function automatic exp_t model(input logic [5:0] s);
      exp_t r;
      r.terms = {s[1] & s[0], s[3] & s[2], s[5] & s[4]};
      r.y     = (s[5] & s[4]) | (s[3] & s[2]) | (s[1] & s[0]);
      return r;
   endfunction

   // Drive one sample at the falling edge, push its expectation, then wait
   // until just after the next rising edge
   task automatic drive(input logic v, input logic [5:0] s, input exp_t ex);
      @(negedge clk);
      u_if.in_valid = v;
      {u_if.a, u_if.b, u_if.c, u_if.d, u_if.e, u_if.f} = s;
      if (v) sb_q.push_back(ex);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      u_if.in_valid = 1'b1;
      {u_if.a, u_if.b, u_if.c, u_if.d, u_if.e, u_if.f} = 6'b111111;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (u_if.y !== 1'b0 || u_if.terms !== 3'b000 || u_if.out_valid !== 1'b0)
            $display("FAIL reset[%0d]: got y=%b terms=%b ov=%b want y=0 terms=000 ov=0",
                     i, u_if.y, u_if.terms, u_if.out_valid);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      u_if.in_valid = 1'b0;
      rst_n         = 1'b1;
      last_exp      = '{y: 1'b0, terms: 3'b000};
   endtask

   task automatic test_single_term();
      exp_t ex;
      drive(1'b1, 6'b001100, '{y: 1'b1, terms: 3'b010});
      ex = sb_q.pop_front();
      last_exp = ex;
      n_checks++;
      if (u_if.y !== ex.y || u_if.terms !== ex.terms || u_if.out_valid !== 1'b1)
         $display("FAIL single_term: got y=%b terms=%b ov=%b want y=%b terms=%b ov=1",
                  u_if.y, u_if.terms, u_if.out_valid, ex.y, ex.terms);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [5:0] stim [3];
      exp_t       want [3];
      exp_t       ex;
      stim[0] = 6'b110111; want[0] = '{y: 1'b1, terms: 3'b101};
      stim[1] = 6'b101101; want[1] = '{y: 1'b1, terms: 3'b010};
      stim[2] = 6'b101010; want[2] = '{y: 1'b0, terms: 3'b000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, stim[i], want[i]);
         ex = sb_q.pop_front();
         last_exp = ex;
         n_checks++;
         if (u_if.y !== ex.y || u_if.terms !== ex.terms || u_if.out_valid !== 1'b1)
            $display("FAIL back_to_back[%0d]: got y=%b terms=%b ov=%b want y=%b terms=%b ov=1",
                     i, u_if.y, u_if.terms, u_if.out_valid, ex.y, ex.terms);
         else n_pass++;
      end
   endtask

   task automatic test_sweep();
      exp_t ex;
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 6'(i), model(6'(i)));
         ex = sb_q.pop_front();
         last_exp = ex;
         n_checks++;
         if (u_if.y !== ex.y || u_if.terms !== ex.terms || u_if.out_valid !== 1'b1)
            $display("FAIL sweep[%0d]: got y=%b terms=%b ov=%b want y=%b terms=%b ov=1",
                     i, u_if.y, u_if.terms, u_if.out_valid, ex.y, ex.terms);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      logic [5:0] idle [5];
      exp_t       ex;
      idle[0] = 6'b111111; idle[1] = 6'b001111; idle[2] = 6'bxxxxxx;
      idle[3] = 6'bzzzzzz; idle[4] = 6'b101011;
      drive(1'b1, 6'b110000, '{y: 1'b1, terms: 3'b001});
      ex = sb_q.pop_front();
      last_exp = ex;
      n_checks++;
      if (u_if.y !== 1'b1 || u_if.terms !== 3'b001 || u_if.out_valid !== 1'b1)
         $display("FAIL hold_load: got y=%b terms=%b ov=%b want y=1 terms=001 ov=1",
                  u_if.y, u_if.terms, u_if.out_valid);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, idle[i], '0);
         n_checks++;
         if (u_if.y !== 1'b1 || u_if.terms !== 3'b001 || u_if.out_valid !== 1'b0)
            $display("FAIL hold[%0d]: got y=%b terms=%b ov=%b want y=1 terms=001 ov=0",
                     i, u_if.y, u_if.terms, u_if.out_valid);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      exp_t ex;
      drive(1'b1, 6'b110000, '{y: 1'b1, terms: 3'b001});
      ex = sb_q.pop_front();
      n_checks++;
      if (u_if.y !== 1'b1 || u_if.out_valid !== 1'b1)
         $display("FAIL mid_reset_pre: got y=%b ov=%b want y=1 ov=1", u_if.y, u_if.out_valid);
      else n_pass++;
      // Assert reset well away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (u_if.y !== 1'b0 || u_if.terms !== 3'b000 || u_if.out_valid !== 1'b0)
         $display("FAIL mid_reset_async: got y=%b terms=%b ov=%b want y=0 terms=000 ov=0",
                  u_if.y, u_if.terms, u_if.out_valid);
      else n_pass++;
      u_if.in_valid = 1'b0;
      #1;
      rst_n = 1'b1;
      last_exp = '{y: 1'b0, terms: 3'b000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 6'b111111, '0);
         n_checks++;
         if (u_if.y !== 1'b0 || u_if.terms !== 3'b000 || u_if.out_valid !== 1'b0)
            $display("FAIL post_reset_idle[%0d]: got y=%b terms=%b ov=%b want y=0 terms=000 ov=0",
                     i, u_if.y, u_if.terms, u_if.out_valid);
         else n_pass++;
      end
      drive(1'b1, 6'b000011, '{y: 1'b1, terms: 3'b100});
      ex = sb_q.pop_front();
      last_exp = ex;
      n_checks++;
      if (u_if.y !== ex.y || u_if.terms !== ex.terms || u_if.out_valid !== 1'b1)
         $display("FAIL post_reset_sample: got y=%b terms=%b ov=%b want y=%b terms=%b ov=1",
                  u_if.y, u_if.terms, u_if.out_valid, ex.y, ex.terms);
      else n_pass++;
      drive(1'b0, 6'b000000, '0);
      n_checks++;
      if (u_if.out_valid !== 1'b0 || u_if.y !== last_exp.y || u_if.terms !== last_exp.terms)
         $display("FAIL post_reset_drop: got y=%b terms=%b ov=%b want y=%b terms=%b ov=0",
                  u_if.y, u_if.terms, u_if.out_valid, last_exp.y, last_exp.terms);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_single_term();
      test_back_to_back();
      test_sweep();
      test_hold();
      test_mid_reset();
      n_checks++;
      if (sb_q.size() != 0)
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
